// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_ctrl_pkg : shared codes for the ALU controller and multiply/divide unit
// Revision 1.0
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_SRAV  = 6'b000111;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  localparam logic [2:0] ALUOP_MEM    = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
  localparam logic [2:0] ALUOP_SLTI   = 3'b011;
  localparam logic [2:0] ALUOP_LUI    = 3'b100;
  localparam logic [2:0] ALUOP_ORI    = 3'b101;
  localparam logic [2:0] ALUOP_XORI   = 3'b110;
  localparam logic [2:0] ALUOP_ADDI   = 3'b111;

  localparam logic [3:0] CTRL_AND  = 4'd0;
  localparam logic [3:0] CTRL_OR   = 4'd1;
  localparam logic [3:0] CTRL_ADD  = 4'd2;
  localparam logic [3:0] CTRL_SUB  = 4'd6;
  localparam logic [3:0] CTRL_SLT  = 4'd7;
  localparam logic [3:0] CTRL_SRA  = 4'd8;
  localparam logic [3:0] CTRL_XOR  = 4'd9;
  localparam logic [3:0] CTRL_LUI  = 4'd10;
  localparam logic [3:0] CTRL_SRAV = 4'd11;
  localparam logic [3:0] CTRL_IDLE = 4'd15;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_HI  = 2'b01;
  localparam logic [1:0] RES_LO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_mdu_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_core : iterative shift-add multiplier / restoring divider with HI/LO
// Revision 1.0
// ---------------------------------------------------------------------------
module mdu_core #(
  parameter int DATA_W    = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              done_o,
  output logic              div_by_zero_o
);
  import alu_ctrl_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  mdu_state_t state_q, state_d;
  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   opd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                is_div_q, neg_lo_q, neg_hi_q;

  logic                is_div, is_signed, a_neg, b_neg, dbz, go;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum, rem_sh;
  logic [DATA_W-1:0]   rem_diff, q_fix, r_fix;
  logic                rem_fits;
  logic [2*DATA_W-1:0] prod_fix;

  // op_i[1] selects divide, op_i[0] selects the unsigned variant
  assign is_div    = op_i[1];
  assign is_signed = SIGNED_EN && !op_i[0];
  assign a_neg     = is_signed & a_i[DATA_W-1];
  assign b_neg     = is_signed & b_i[DATA_W-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;
  assign dbz       = start_i & is_div & (b_i == '0);
  assign go        = start_i & !dbz;

  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  // The partial remainder is below the divisor after a successful subtract, so W bits suffice
  assign rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign rem_fits = (rem_sh >= {1'b0, opd_q});
  assign rem_diff = rem_sh[DATA_W-1:0] - opd_q;

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign q_fix    = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign r_fix    = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

  assign busy_o = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = is_div ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q         <= '0;
      opd_q         <= '0;
      cnt_q         <= '0;
      is_div_q      <= 1'b0;
      neg_lo_q      <= 1'b0;
      neg_hi_q      <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      done_o        <= (state_q == ST_FIX);
      div_by_zero_o <= dbz;
      case (state_q)
        ST_IDLE: if (go) begin
          acc_q    <= {{DATA_W{1'b0}}, is_div ? a_mag : b_mag};
          opd_q    <= is_div ? b_mag : a_mag;
          cnt_q    <= '0;
          is_div_q <= is_div;
          neg_lo_q <= a_neg ^ b_neg;
          neg_hi_q <= is_div ? a_neg : (a_neg ^ b_neg);
        end
        ST_MUL: begin
          acc_q <= {mul_sum, acc_q[DATA_W-1:1]};
          cnt_q <= cnt_q + 1'b1;
        end
        ST_DIV: begin
          acc_q <= {rem_fits ? rem_diff : rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], rem_fits};
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
      if (state_q == ST_FIX) begin
        if (is_div_q) begin
          hi_o <= r_fix;
          lo_o <= q_fix;
        end else begin
          {hi_o, lo_o} <= prod_fix;
        end
      end else begin
        if (hi_we_i) hi_o <= wdata_i;
        if (lo_we_i) lo_o <= wdata_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_mdu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_ctrl_mdu : ALU control decode, HI/LO interlock and mthi/mtlo write path
// Revision 1.0
// ---------------------------------------------------------------------------
module alu_ctrl_mdu #(
  parameter int DATA_W    = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [5:0]        funct_i,
  input  logic [2:0]        ALUOp_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  output logic [3:0]        ALUCtrl_o,
  output logic [1:0]        res_sel_o,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              done_o,
  output logic              div_by_zero_o
);
  import alu_ctrl_pkg::*;

  logic rtype, mdu_op, hilo_op, issue, hi_we, lo_we, busy;

  assign rtype   = (ALUOp_i == ALUOP_RTYPE);
  assign mdu_op  = (funct_i[5:2] == 4'b0110);
  assign hilo_op = (funct_i[5:2] == 4'b0100);
  assign stall_o = valid_i & rtype & (mdu_op | hilo_op) & busy;
  assign issue   = valid_i & rtype & mdu_op & !stall_o;
  assign hi_we   = valid_i & rtype & (funct_i == FUNCT_MTHI) & !stall_o;
  assign lo_we   = valid_i & rtype & (funct_i == FUNCT_MTLO) & !stall_o;
  assign busy_o  = busy;

  always_comb begin
    ALUCtrl_o = CTRL_ADD;
    res_sel_o = RES_ALU;
    if (rtype) begin
      if (mdu_op || hilo_op) begin
        ALUCtrl_o = CTRL_IDLE;
      end else begin
        case (funct_i)
          FUNCT_ADDU: ALUCtrl_o = CTRL_ADD;
          FUNCT_SUBU: ALUCtrl_o = CTRL_SUB;
          FUNCT_AND:  ALUCtrl_o = CTRL_AND;
          FUNCT_OR:   ALUCtrl_o = CTRL_OR;
          FUNCT_SLT:  ALUCtrl_o = CTRL_SLT;
          FUNCT_SRA:  ALUCtrl_o = CTRL_SRA;
          FUNCT_SRAV: ALUCtrl_o = CTRL_SRAV;
          default:    ALUCtrl_o = CTRL_ADD;
        endcase
      end
      if (funct_i == FUNCT_MFHI)      res_sel_o = RES_HI;
      else if (funct_i == FUNCT_MFLO) res_sel_o = RES_LO;
    end else begin
      case (ALUOp_i)
        ALUOP_MEM:    ALUCtrl_o = CTRL_ADD;
        ALUOP_BRANCH: ALUCtrl_o = CTRL_SUB;
        ALUOP_SLTI:   ALUCtrl_o = CTRL_SLT;
        ALUOP_LUI:    ALUCtrl_o = CTRL_LUI;
        ALUOP_ORI:    ALUCtrl_o = CTRL_OR;
        ALUOP_XORI:   ALUCtrl_o = CTRL_XOR;
        ALUOP_ADDI:   ALUCtrl_o = CTRL_ADD;
        default:      ALUCtrl_o = CTRL_ADD;
      endcase
    end
  end

  mdu_core #(
    .DATA_W    (DATA_W),
    .SIGNED_EN (SIGNED_EN)
  ) u_mdu_core (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (issue),
    .op_i          (funct_i[1:0]),
    .a_i           (rs_data_i),
    .b_i           (rt_data_i),
    .hi_we_i       (hi_we),
    .lo_we_i       (lo_we),
    .wdata_i       (rs_data_i),
    .busy_o        (busy),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_mdu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_ctrl_mdu : scoreboard bench with an arithmetic reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_alu_ctrl_mdu;

  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO = 6'b010011;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU = 6'b011011;

  logic        clk = 1'b0, rst = 1'b0, valid = 1'b0;
  logic [5:0]  funct = '0;
  logic [2:0]  aluop = '0;
  logic [31:0] rs = '0, rt = '0;
  logic [3:0]  alu_ctrl;
  logic [1:0]  res_sel;
  logic        stall, busy, done, dbz;
  logic [31:0] hi, lo;

  alu_ctrl_mdu #(.DATA_W(32), .SIGNED_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .funct_i(funct), .ALUOp_i(aluop),
    .rs_data_i(rs), .rt_data_i(rt), .ALUCtrl_o(alu_ctrl), .res_sel_o(res_sel),
    .stall_o(stall), .busy_o(busy), .hi_o(hi), .lo_o(lo), .done_o(done),
    .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [5:0]  ftab [16] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010,
                             6'b000011, 6'b000111, 6'b010000, 6'b010001, 6'b010010,
                             6'b010011, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
                             6'b111111};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [2:0] op, input logic [5:0] f);
    if (op != 3'b010) begin
      case (op)
        3'b000: return 4'd2;  3'b001: return 4'd6;  3'b011: return 4'd7;
        3'b100: return 4'd10; 3'b101: return 4'd1;  3'b110: return 4'd9;
        default: return 4'd2;
      endcase
    end
    if (f inside {[6'b010000:6'b010011], [6'b011000:6'b011011]}) return 4'd15;
    case (f)
      6'b100001: return 4'd2;  6'b100011: return 4'd6; 6'b100100: return 4'd0;
      6'b100101: return 4'd1;  6'b101010: return 4'd7; 6'b000011: return 4'd8;
      6'b000111: return 4'd11;
      default: return 4'd2;
    endcase
  endfunction

  // Returns {HI, LO} from plain 64-bit arithmetic
  function automatic logic [63:0] mdu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, ua, ub, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    res = '0;
    case (f)
      F_MULT:  res = sa * sbv;
      F_MULTU: res = ua * ub;
      F_DIV:   begin q = sa / sbv; r = sa % sbv; res = {r[31:0], q[31:0]}; end
      F_DIVU:  begin q = ua / ub;  r = ua % ub;  res = {r[31:0], q[31:0]}; end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (done || dbz)) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {62'd0, done, dbz}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result_kind", {63'd0, dbz}, {63'd0, e.is_dbz});
        check("result_hi", {32'd0, hi}, {32'd0, e.hi});
        check("result_lo", {32'd0, lo}, {32'd0, e.lo});
      end
    end
  end

  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int waited);
    logic [63:0] r;
    exp_t e;
    waited = 0;
    @(negedge clk);
    valid = 1'b1; aluop = 3'b010; funct = f; rs = a; rt = b;
    #1;
    while (stall && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (waited >= 200) check("stall_timeout", {63'd0, stall}, 64'd0);
    if (f == F_MFHI) begin
      check("mfhi_sel", {62'd0, res_sel}, 64'd1);
      check("mfhi_value", {32'd0, hi}, {32'd0, m_hi});
    end
    if (f == F_MFLO) begin
      check("mflo_sel", {62'd0, res_sel}, 64'd2);
      check("mflo_value", {32'd0, lo}, {32'd0, m_lo});
    end
    if (f inside {F_MULT, F_MULTU, F_DIV, F_DIVU}) begin
      if (f[1] && b == 32'd0) begin
        e.is_dbz = 1'b1;
      end else begin
        r = mdu_ref(f, a, b);
        m_hi = r[63:32];
        m_lo = r[31:0];
        e.is_dbz = 1'b0;
      end
      e.hi = m_hi;
      e.lo = m_lo;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    valid = 1'b0; aluop = 3'b000; funct = 6'd0;
    if (f == F_MTHI) begin m_hi = a; check("mthi_write", {32'd0, hi}, {32'd0, a}); end
    if (f == F_MTLO) begin m_lo = a; check("mtlo_write", {32'd0, lo}, {32'd0, a}); end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    logic [31:0] old_hi;
    logic [5:0]  f;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_done", {62'd0, done, dbz}, 64'd0);
    rst = 1'b0;

    @(negedge clk);
    aluop = 3'b010; funct = 6'b100011; #1; check("dec_subu", {60'd0, alu_ctrl}, 64'd6);
    funct = 6'b000111; #1; check("dec_srav", {60'd0, alu_ctrl}, 64'd11);
    funct = 6'b111111; #1; check("dec_other", {60'd0, alu_ctrl}, 64'd2);
    aluop = 3'b100;    #1; check("dec_aluop4", {60'd0, alu_ctrl}, 64'd10);
    for (int i = 0; i < 40; i++) begin
      aluop = 3'($urandom);
      funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ftab[$urandom_range(0, 15)];
      #1;
      check("dec_rand_ctrl", {60'd0, alu_ctrl}, {60'd0, ref_ctrl(aluop, funct)});
      check("dec_rand_sel", {62'd0, res_sel},
            {62'd0, (aluop == 3'b010 && funct == F_MFHI) ? 2'b01 :
                    (aluop == 3'b010 && funct == F_MFLO) ? 2'b10 : 2'b00});
      check("dec_rand_stall", {63'd0, stall}, 64'd0);
    end
    aluop = 3'b000; funct = 6'd0;

    send(F_MULT, 32'hFFFF_FFFD, 32'd7, w);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("mult_busy_cycles", n, 64'd33);
    check("mult_done_pulse", {63'd0, done}, 64'd1);
    check("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'd0, lo}, 64'hFFFF_FFEB);
    @(posedge clk); #1;
    check("mult_done_single", {63'd0, done}, 64'd0);

    send(F_DIVU, 32'd100, 32'd7, w); wait_idle();
    check("divu_lo", {32'd0, lo}, 64'd14);
    check("divu_hi", {32'd0, hi}, 64'd2);
    send(F_DIV, 32'hFFFF_FFF9, 32'd2, w); wait_idle();
    check("div_neg_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    send(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, w); wait_idle();
    check("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
    check("div_ovf_hi", {32'd0, hi}, 64'd0);

    send(F_MULT, 32'h0001_2345, 32'hFFF0_0011, w);
    send(F_MFLO, 32'd0, 32'd0, w);
    check("mflo_stall_cycles", w, 64'd33);
    old_hi = m_hi;
    send(F_MULTU, 32'hDEAD_0001, 32'h0000_BEEF, w);
    @(negedge clk);
    valid = 1'b1; aluop = 3'b010; funct = F_MTHI; rs = 32'hCAFE_F00D; #1;
    check("mthi_busy_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    check("mthi_busy_hi", {32'd0, hi}, {32'd0, old_hi});
    valid = 1'b0; aluop = 3'b000; funct = 6'd0;
    wait_idle();

    send(F_DIV, $urandom, 32'h0000_0013, w);
    send(F_MULTU, $urandom, $urandom, w);
    check("b2b_stall_cycles", w, 64'd33);
    wait_idle();

    send(F_MTHI, 32'd5, 32'd0, w);
    send(F_MTLO, 32'd6, 32'd0, w);
    send(F_DIV, 32'd123, 32'd0, w);
    check("dbz_pulse", {63'd0, dbz}, 64'd1);
    check("dbz_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("dbz_single", {63'd0, dbz}, 64'd0);
    check("dbz_hi", {32'd0, hi}, 64'd5);
    check("dbz_lo", {32'd0, lo}, 64'd6);

    send(F_MULT, 32'h1234_5678, 32'h9ABC_DEF1, w);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hi", {32'd0, hi}, 64'd0);
    check("rst_mid_lo", {32'd0, lo}, 64'd0);
    sb.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    send(F_MULTU, 32'd3, 32'd4, w); wait_idle();
    check("post_rst_lo", {32'd0, lo}, 64'd12);
    check("post_rst_hi", {32'd0, hi}, 64'd0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 7))
        0: f = F_MULT;  1: f = F_MULTU; 2: f = F_DIV;  3: f = F_DIVU;
        4: f = F_MTHI;  5: f = F_MTLO;  6: f = F_MFHI; default: f = F_MFLO;
      endcase
      send(f, pick_operand(), pick_operand(), w);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    wait_idle();
    check("scoreboard_drained", sb.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
